// File: rtl/fetch.sv
// fetch: instruction fetch stage feeding decode from a 16-bit handshaked instruction memory.
// Latency: a returned word reaches instr/PC/valid on the edge that accepts it (zero added cycles).
// Backpressure: stall freezes the output slot; a word arriving while stalled parks in a skid register (HOLD).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    decode cannot take a new instruction this cycle
//   redirect, redirect_pc    taken branch/jump and its byte target (bit 0 set flags err)
//   halt                     the instruction in the output slot is HALT
//   imem_rd, imem_addr       read request, held stable until imem_ready
//   imem_data, imem_ready    read data and completion strobe
//   instr, PC, PC_Next       instruction to decode, its byte address, and PC + 2
//   valid                    instr/PC/PC_Next carry a live instruction
//   err                      one-cycle pulse on a misaligned redirect target
module fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_ready,
  output logic [15:0] instr,
  output logic [15:0] PC,
  output logic [15:0] PC_Next,
  output logic        valid,
  output logic        err
);

  localparam logic [15:0] NOP_WORD = 16'h0800;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] fpc_q;        // address of the next word to request
  logic        squash_q;     // outstanding request belongs to a redirected-away path
  logic [15:0] sq_addr_q;    // address of that abandoned request, kept on imem_addr until it completes
  logic        halt_pend_q;  // halt seen while a request was in flight; stop once it completes
  logic [15:0] skid_q;
  logic [15:0] instr_q;
  logic [15:0] pc_q;
  logic        valid_q;
  logic        err_q;

  logic        slot_free;
  logic        halt_take;
  logic [15:0] redir_tgt;
  logic [15:0] fpc_plus2;

  assign slot_free = !valid_q || !stall;
  // Redirect is checked first in the state update, so it always overrides halt.
  assign halt_take = halt && valid_q;
  assign redir_tgt = {redirect_pc[15:1], 1'b0};
  assign fpc_plus2 = fpc_q + 16'd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      fpc_q       <= 16'h0000;
      squash_q    <= 1'b0;
      sq_addr_q   <= 16'h0000;
      halt_pend_q <= 1'b0;
      skid_q      <= 16'h0000;
      instr_q     <= NOP_WORD;
      pc_q        <= 16'h0000;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_HALTED: begin
          // Frozen until reset; redirect and halt are ignored here.
        end

        default: begin
          if (redirect) begin
            fpc_q       <= redir_tgt;
            err_q       <= redirect_pc[0];
            valid_q     <= 1'b0;
            state_q     <= S_FETCH;
            halt_pend_q <= 1'b0;
            // A request still in flight must run to completion on the bus,
            // so remember to drop its data. If it completes this very cycle
            // the word is simply not loaded and nothing needs remembering.
            if (state_q == S_FETCH && !imem_ready) begin
              squash_q <= 1'b1;
              if (!squash_q) begin
                sq_addr_q <= fpc_q;
              end
            end else begin
              squash_q <= 1'b0;
            end
          end else if (state_q == S_HOLD) begin
            if (halt_take) begin
              // No request is outstanding in HOLD, so halt immediately.
              valid_q <= 1'b0;
              state_q <= S_HALTED;
            end else if (slot_free) begin
              // fpc already advanced past the parked word.
              instr_q <= skid_q;
              pc_q    <= fpc_q - 16'd2;
              valid_q <= 1'b1;
              state_q <= S_FETCH;
            end
          end else begin
            // S_FETCH: a request is always outstanding here.
            if (halt_take) begin
              valid_q <= 1'b0;
              if (imem_ready) begin
                state_q <= S_HALTED;
              end else begin
                halt_pend_q <= 1'b1;
              end
            end else if (imem_ready) begin
              if (squash_q) begin
                squash_q <= 1'b0;
                if (slot_free) begin
                  valid_q <= 1'b0;
                end
              end else if (halt_pend_q) begin
                halt_pend_q <= 1'b0;
                state_q     <= S_HALTED;
              end else if (slot_free) begin
                instr_q <= imem_data;
                pc_q    <= fpc_q;
                valid_q <= 1'b1;
                fpc_q   <= fpc_plus2;
              end else begin
                skid_q  <= imem_data;
                fpc_q   <= fpc_plus2;
                state_q <= S_HOLD;
              end
            end else if (slot_free) begin
              valid_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign imem_rd   = (state_q == S_FETCH);
  assign imem_addr = squash_q ? sq_addr_q : fpc_q;

  assign instr   = instr_q;
  assign PC      = pc_q;
  assign PC_Next = pc_q + 16'd2;
  assign valid   = valid_q;
  assign err     = err_q;

endmodule
